// File: rtl/edge_grad_engine.sv
// Row-wise horizontal gradient edge detector: streams 16-bit pixels from memory over
// Avalon-MM, thresholds |p[x+1]-p[x-1]| and writes 0x00FF/0x0000 results back.
module edge_grad_engine #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        done,
  output logic        busy,
  input  logic [31:0] cfg_src_base,
  input  logic [31:0] cfg_dst_base,
  input  logic [7:0]  cfg_thresh,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [15:0] avm_writedata,
  output logic [1:0]  avm_byteenable,
  input  logic [15:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_LAST, DONE} state_t;

  state_t      state_reg, state_next;
  logic        start_d_reg;
  logic [31:0] src_base_reg, src_base_next;
  logic [31:0] dst_base_reg, dst_base_next;
  logic [7:0]  thresh_reg, thresh_next;
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic [31:0] rd_off_reg, rd_off_next;
  logic [31:0] wr_off_reg, wr_off_next;
  logic [7:0]  p1_reg, p1_next;
  logic [7:0]  p2_reg, p2_next;
  logic [15:0] wr_data_reg, wr_data_next;

  logic [7:0] pix;
  logic [8:0] diff;
  logic [7:0] mag;
  logic       edge_hit;
  logic       unused_hi;

  // Upper byte of each pixel word carries no image data.
  assign unused_hi = ^avm_readdata[15:8];
  assign pix       = avm_readdata[7:0];
  // p2_reg still holds p[x-2] when p[x] arrives.
  assign diff      = {1'b0, pix} - {1'b0, p2_reg};
  assign mag       = diff[8] ? (~diff[7:0] + 8'd1) : diff[7:0];
  assign edge_hit  = mag > thresh_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      start_d_reg  <= 1'b1;
      src_base_reg <= '0;
      dst_base_reg <= '0;
      thresh_reg   <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      rd_off_reg   <= '0;
      wr_off_reg   <= '0;
      p1_reg       <= '0;
      p2_reg       <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      start_d_reg  <= start;
      src_base_reg <= src_base_next;
      dst_base_reg <= dst_base_next;
      thresh_reg   <= thresh_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      rd_off_reg   <= rd_off_next;
      wr_off_reg   <= wr_off_next;
      p1_reg       <= p1_next;
      p2_reg       <= p2_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    src_base_next  = src_base_reg;
    dst_base_next  = dst_base_reg;
    thresh_next    = thresh_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    rd_off_next    = rd_off_reg;
    wr_off_next    = wr_off_reg;
    p1_next        = p1_reg;
    p2_next        = p2_reg;
    wr_data_next   = wr_data_reg;
    done           = 1'b0;
    busy           = 1'b0;
    avm_address    = '0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_writedata  = '0;
    avm_byteenable = '0;

    case (state_reg)
      IDLE: begin
        if (start && !start_d_reg) begin
          src_base_next = cfg_src_base;
          dst_base_next = cfg_dst_base;
          thresh_next   = cfg_thresh;
          x_next        = '0;
          y_next        = '0;
          rd_off_next   = '0;
          wr_off_next   = '0;
          p1_next       = '0;
          p2_next       = '0;
          state_next    = RD_REQ;
        end
      end
      RD_REQ: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = src_base_reg + rd_off_reg;
        if (!avm_waitrequest) begin
          rd_off_next = rd_off_reg + 32'd2;
          state_next  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        busy = 1'b1;
        if (avm_readdatavalid) begin
          p2_next = p1_reg;
          p1_next = pix;
          if (x_reg == '0) begin
            wr_data_next = 16'h0000;
            state_next   = WR_REQ;
          end else if (x_reg == XW'(1)) begin
            // Need p[x+1] before out[x] can be formed.
            x_next     = x_reg + XW'(1);
            state_next = RD_REQ;
          end else begin
            wr_data_next = edge_hit ? 16'h00FF : 16'h0000;
            state_next   = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        busy           = 1'b1;
        avm_write      = 1'b1;
        avm_byteenable = 2'b11;
        avm_address    = dst_base_reg + wr_off_reg;
        avm_writedata  = wr_data_reg;
        if (!avm_waitrequest) begin
          wr_off_next = wr_off_reg + 32'd2;
          if (x_reg == X_LAST) begin
            state_next = WR_LAST;
          end else begin
            x_next     = x_reg + XW'(1);
            state_next = RD_REQ;
          end
        end
      end
      WR_LAST: begin
        busy           = 1'b1;
        avm_write      = 1'b1;
        avm_byteenable = 2'b11;
        avm_address    = dst_base_reg + wr_off_reg;
        if (!avm_waitrequest) begin
          wr_off_next = wr_off_reg + 32'd2;
          if (y_reg == Y_LAST) begin
            state_next = DONE;
          end else begin
            y_next     = y_reg + YW'(1);
            x_next     = '0;
            p1_next    = '0;
            p2_next    = '0;
            state_next = RD_REQ;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_edge_grad_engine.sv
// Bench for edge_grad_engine: 4x2 image, Avalon slave model with stalls and
// variable read latency, table vectors plus random frames against a row model.
module tb_edge_grad_engine;
  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b1;
  logic        done;
  logic        busy;
  logic [31:0] cfg_src_base = '0;
  logic [31:0] cfg_dst_base = '0;
  logic [7:0]  cfg_thresh = '0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic [15:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;

  always #5 clk = ~clk;

  edge_grad_engine #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .done(done), .busy(busy),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_thresh(cfg_thresh),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  int checks = 0;
  int errors = 0;

  // Slave model state
  logic [15:0] mem [0:255];
  int stall_n = 0, stall_cnt = 0, rd_delay_max = 0, rd_delay_fixed = -1;
  bit spurious = 1'b0;
  bit pend = 1'b0;
  int pend_dly = 0;
  logic [15:0] pend_data = '0;
  logic [31:0] rd_addr_q[$];
  logic [31:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int stab_viol = 0, both_viol = 0, be_viol = 0;
  logic [31:0] prev_addr = '0;
  logic [15:0] prev_wd = '0;
  logic prev_rd = 1'b0, prev_wr = 1'b0, prev_wait = 1'b0;

  always @(negedge clk) begin
    avm_readdatavalid = 1'b0;
    if (avm_read && avm_write) both_viol++;
    if (avm_write && avm_byteenable !== 2'b11) be_viol++;
    if (prev_wait && (prev_rd || prev_wr) &&
        {avm_read, avm_write, avm_address, avm_writedata} !== {prev_rd, prev_wr, prev_addr, prev_wd})
      stab_viol++;
    prev_rd = avm_read; prev_wr = avm_write; prev_addr = avm_address; prev_wd = avm_writedata;
    if (pend) begin
      if (pend_dly == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = pend_data;
        pend = 1'b0;
      end else pend_dly--;
    end else if (spurious && (avm_read || avm_write) && $urandom_range(1, 0) == 1) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = 16'($urandom);
    end
    if (avm_read || avm_write) begin
      if (stall_cnt < stall_n) begin
        avm_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        avm_waitrequest = 1'b0;
        stall_cnt = 0;
        if (avm_read) begin
          rd_addr_q.push_back(avm_address);
          pend = 1'b1;
          pend_dly = (rd_delay_fixed >= 0) ? rd_delay_fixed : int'($urandom_range(rd_delay_max, 0));
          pend_data = mem[avm_address[8:1]];
        end else begin
          wr_addr_q.push_back(avm_address);
          wr_data_q.push_back(avm_writedata);
        end
      end
    end else begin
      avm_waitrequest = 1'b0;
      stall_cnt = 0;
    end
    prev_wait = avm_waitrequest;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Expected output word for every pixel, derived row by row from the image.
  task automatic ref_model(input logic [7:0] p[N], input logic [7:0] th, output logic [15:0] e[N]);
    int d;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        e[r*W+c] = 16'h0000;
        if (c > 0 && c < W - 1) begin
          d = int'(p[r*W+c+1]) - int'(p[r*W+c-1]);
          if (d < 0) d = -d;
          if (d > int'(th)) e[r*W+c] = 16'h00FF;
        end
      end
  endtask

  task automatic load_frame(input logic [31:0] src, input logic [7:0] p[N]);
    for (int i = 0; i < N; i++)
      mem[(int'(src[8:1]) + i) % 256] = {8'($urandom), p[i]};
  endtask

  task automatic run_frame(input string tag, input logic [31:0] src, input logic [31:0] dst,
                           input logic [7:0] th, input logic [15:0] e[N],
                           input bit glitch, input int hold);
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    cfg_src_base = src; cfg_dst_base = dst; cfg_thresh = th;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    if (glitch) begin
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
    end
    for (int c = 0; c < 3000 && done !== 1'b1; c++) @(negedge clk);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, " done_held"}, 32'(done), 32'd1);
    end
    chk({tag, " nreads"}, 32'(rd_addr_q.size()), 32'(N));
    chk({tag, " nwrites"}, 32'(wr_addr_q.size()), 32'(N));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s rd_addr[%0d]", tag, i),
          (i < rd_addr_q.size()) ? rd_addr_q[i] : 32'hxxxxxxxx, src + 32'(2 * i));
      chk($sformatf("%s wr_addr[%0d]", tag, i),
          (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hxxxxxxxx, dst + 32'(2 * i));
      chk($sformatf("%s wr_data[%0d]", tag, i),
          (i < wr_data_q.size()) ? 32'(wr_data_q[i]) : 32'hxxxxxxxx, 32'(e[i]));
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, " done_clear"}, 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  pix [N];
    logic [7:0]  th;
    logic [15:0] exp [N];
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [7:0]  rp [N];
    logic [15:0] re [N];
    logic [7:0]  rth;

    tbl[0].pix = '{8'd10, 8'd50, 8'd60, 8'd30, 8'd100, 8'd0, 8'd125, 8'd0};
    tbl[0].th  = 8'd25;
    tbl[0].exp = '{16'h0, 16'hFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    tbl[1].pix = '{8'd100, 8'd0, 8'd126, 8'd7, 8'd125, 8'd0, 8'd100, 8'd200};
    tbl[1].th  = 8'd25;
    tbl[1].exp = '{16'h0, 16'hFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFF, 16'h0};
    tbl[2].pix = '{8'd125, 8'd0, 8'd99, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0};
    tbl[2].th  = 8'd25;
    tbl[2].exp = '{16'h0, 16'hFF, 16'h0, 16'h0, 16'h0, 16'hFF, 16'hFF, 16'h0};
    tbl[3].pix = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0};
    tbl[3].th  = 8'd255;
    tbl[3].exp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    tbl[4].pix = '{8'd5, 8'd5, 8'd6, 8'd5, 8'd7, 8'd7, 8'd7, 8'd7};
    tbl[4].th  = 8'd0;
    tbl[4].exp = '{16'h0, 16'hFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state, with start held high across reset release
    repeat (3) @(negedge clk);
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst read", 32'(avm_read), 32'd0);
    chk("rst write", 32'(avm_write), 32'd0);
    chk("rst address", avm_address, 32'd0);
    chk("rst writedata", 32'(avm_writedata), 32'd0);
    chk("rst byteenable", 32'(avm_byteenable), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("start_held busy", 32'(busy), 32'd0);
    chk("start_held nreads", 32'(rd_addr_q.size()), 32'd0);

    // Table vectors, random read latency and ignored stray readdatavalid
    rd_delay_max = 2;
    spurious = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_frame(32'h8000_0040, tbl[i].pix);
      run_frame($sformatf("vec%0d", i), 32'h8000_0040, 32'h1000_0200 + 32'(i * 256),
                tbl[i].th, tbl[i].exp, 1'b0, 0);
    end

    // Every request stalled 5 cycles
    stall_n = 5;
    load_frame(32'h0000_0080, tbl[0].pix);
    run_frame("stall5", 32'h0000_0080, 32'h0000_0400, tbl[0].th, tbl[0].exp, 1'b0, 0);
    stall_n = 0;

    // Start edge while busy ignored; start held after DONE does not retrigger
    load_frame(32'h0000_0040, tbl[1].pix);
    run_frame("glitch", 32'h0000_0040, 32'h0000_0300, tbl[1].th, tbl[1].exp, 1'b1, 12);
    run_frame("restart", 32'h0000_0040, 32'h0000_0320, tbl[1].th, tbl[1].exp, 1'b0, 0);

    // Reset in RD_WAIT, readdatavalid arrives after release
    spurious = 1'b0;
    rd_delay_fixed = 15;
    load_frame(32'h0000_0040, tbl[0].pix);
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 50 && !pend; c++) @(negedge clk);
    @(negedge clk);
    chk("rst_mid busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid busy_in_reset", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_mid rdv_delivered", 32'(pend), 32'd0);
    chk("rst_mid nwrites", 32'(wr_addr_q.size()), 32'd0);
    chk("rst_mid nreads", 32'(rd_addr_q.size()), 32'd1);
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid done", 32'(done), 32'd0);
    rd_delay_fixed = -1;

    // Random frames against the row model
    spurious = 1'b1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N; i++) rp[i] = 8'($urandom);
      rth = (f % 2 == 0) ? 8'($urandom) : 8'($urandom_range(40, 0));
      stall_n = int'($urandom_range(3, 0));
      rd_delay_max = int'($urandom_range(3, 0));
      ref_model(rp, rth, re);
      load_frame(32'h0000_0100, rp);
      run_frame($sformatf("rand%0d", f), 32'h0000_0100, 32'h2000_0000 + 32'(f * 64),
                rth, re, 1'b0, 0);
    end

    chk("bus stable_while_waiting", 32'(stab_viol), 32'd0);
    chk("bus read_write_overlap", 32'(both_viol), 32'd0);
    chk("bus byteenable", 32'(be_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
